// File: rtl/packer_arb_pkg.sv
// packer_arb_pkg: shared types and sizing helpers for the packer arbiter.
//   state_e : arbiter FSM states (Idle, Busy, Flush)
//   idx_w   : width of a requester index, never less than one bit
//   wdog_w  : width of the idle-grant watchdog counter
package packer_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   function automatic int idx_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int wdog_w(input int t);
      int w;
      w = $clog2(t + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/packer_arb_rr_pick.sv
// packer_arb_rr_pick: combinational round-robin picker.
// Returns the first set request at or after rr_ptr, searching upward
// with wrap-around modulo NumReq (non-power-of-two NumReq supported).
// Ports:
//   req    in  NumReq  request vector
//   rr_ptr in  IdxW    highest-priority index for this pick
//   any_o  out 1       at least one request is set
//   idx_o  out IdxW    winning index (0 when no request)
module packer_arb_rr_pick #(
   parameter int NumReq = 4,
   parameter int IdxW   = 2
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   rr_ptr,
   output logic              any_o,
   output logic [IdxW-1:0]   idx_o
);

   localparam logic [IdxW:0] NReq = (IdxW + 1)'(NumReq);

   // One extra bit so rr_ptr + offset cannot overflow before the wrap.
   logic [IdxW:0] cand;

   // Walk offsets from farthest to nearest so the nearest set request
   // is the last one written and therefore wins.
   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      cand  = '0;
      for (int off = NumReq - 1; off >= 0; off--) begin
         cand = {1'b0, rr_ptr} + (IdxW + 1)'(off);
         if (cand >= NReq) begin
            cand = cand - NReq;
         end
         if (req[cand[IdxW-1:0]]) begin
            any_o = 1'b1;
            idx_o = cand[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/packer_arb.sv
// packer_arb: round-robin arbiter placing NumReq burst sources onto one
// packer input and sequencing the packer flush between bursts, so each
// requester's data is packed and emitted contiguously.
// Optional feature macro: PACKER_ARB_WDOG_EN enables an idle-grant
// watchdog that force-flushes a burst whose owner stays silent for
// TimeoutCycles Busy cycles.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_valid_i       per-requester beat valid          [NumReq]
//   req_data_i        per-requester data, k at [k*InW +: InW]
//   req_mask_i        per-requester mask, same slicing
//   req_last_i        per-requester last beat of burst  [NumReq]
//   req_ready_o       per-requester ready               [NumReq]
//   pk_valid_o/pk_data_o/pk_mask_o  packer input beat
//   pk_ready_i        packer ready
//   pk_flush_o        packer flush request
//   pk_flush_done_i   packer flush complete
//   grant_valid_o     a requester owns the packer
//   grant_idx_o       owning requester index            [IdxW]
//   wdog_o            one-cycle watchdog pulse (0 without the macro)
module packer_arb
   import packer_arb_pkg::*;
#(
   parameter int  NumReq        = 4,
   parameter int  InW           = 32,
   parameter int  TimeoutCycles = 256,
   localparam int IdxW          = idx_w(NumReq)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NumReq-1:0]     req_valid_i,
   input  logic [NumReq*InW-1:0] req_data_i,
   input  logic [NumReq*InW-1:0] req_mask_i,
   input  logic [NumReq-1:0]     req_last_i,
   output logic [NumReq-1:0]     req_ready_o,
   output logic                  pk_valid_o,
   output logic [InW-1:0]        pk_data_o,
   output logic [InW-1:0]        pk_mask_o,
   input  logic                  pk_ready_i,
   output logic                  pk_flush_o,
   input  logic                  pk_flush_done_i,
   output logic                  grant_valid_o,
   output logic [IdxW-1:0]       grant_idx_o,
   output logic                  wdog_o
);

   if (NumReq < 2) begin : g_bad_numreq
      $error("packer_arb: NumReq must be at least 2");
   end
   if (TimeoutCycles < 1) begin : g_bad_timeout
      $error("packer_arb: TimeoutCycles must be at least 1");
   end

   state_e          state, state_nxt;
   logic [IdxW-1:0] rr_ptr, rr_nxt;
   logic [IdxW-1:0] grant_idx, grant_nxt;
   logic            pick_any;
   logic [IdxW-1:0] pick_idx;
   logic            wdog_fire;

   logic [InW-1:0] data_arr [NumReq];
   logic [InW-1:0] mask_arr [NumReq];

   for (genvar k = 0; k < NumReq; k++) begin : g_slice
      assign data_arr[k] = req_data_i[k*InW +: InW];
      assign mask_arr[k] = req_mask_i[k*InW +: InW];
   end

   logic           g_valid, g_last;
   logic [InW-1:0] g_data, g_mask;

   assign g_valid = req_valid_i[grant_idx];
   assign g_last  = req_last_i[grant_idx];
   assign g_data  = data_arr[grant_idx];
   assign g_mask  = mask_arr[grant_idx];

   function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
      return (i == IdxW'(NumReq - 1)) ? '0 : i + IdxW'(1);
   endfunction

   packer_arb_rr_pick #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_pick (
      .req    (req_valid_i),
      .rr_ptr (rr_ptr),
      .any_o  (pick_any),
      .idx_o  (pick_idx)
   );

`ifdef PACKER_ARB_WDOG_EN
   localparam int WdW = wdog_w(TimeoutCycles);

   logic [WdW-1:0] wd_cnt;

   // Held at zero outside Busy, so every grant starts from a clean count.
   // A stalled-but-valid owner (pk_ready low) neither counts nor clears.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_cnt <= '0;
      end else if (state != ST_BUSY || (g_valid && pk_ready_i)) begin
         wd_cnt <= '0;
      end else if (!g_valid) begin
         wd_cnt <= wd_cnt + WdW'(1);
      end
   end

   // Fires in the TimeoutCycles-th consecutive silent Busy cycle.
   assign wdog_fire = (state == ST_BUSY) && !g_valid &&
                      (wd_cnt == WdW'(TimeoutCycles - 1));
`else
   assign wdog_fire = 1'b0;
`endif

   assign wdog_o        = wdog_fire;
   assign grant_valid_o = (state == ST_BUSY);
   assign grant_idx_o   = grant_idx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_nxt;
         grant_idx <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      rr_nxt      = rr_ptr;
      grant_nxt   = grant_idx;
      req_ready_o = '0;
      pk_valid_o  = 1'b0;
      pk_data_o   = '0;
      pk_mask_o   = '0;
      pk_flush_o  = 1'b0;
      case (state)
         ST_IDLE: begin
            // Arbitration cycle: nothing is accepted here.
            if (pick_any) begin
               grant_nxt = pick_idx;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            pk_valid_o             = g_valid;
            pk_data_o              = g_data;
            pk_mask_o              = g_mask;
            req_ready_o[grant_idx] = pk_ready_i;
            // wdog_fire implies the owner is silent, so it never races
            // an accepted beat.
            if ((g_valid && pk_ready_i && g_last) || wdog_fire) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            pk_flush_o = 1'b1;
            if (pk_flush_done_i) begin
               rr_nxt    = wrap_inc(grant_idx);
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_packer_arb.sv
// tb_packer_arb: randomized scoreboard bench for packer_arb.
// Stimulus pushes each generated beat to a per-requester source queue
// (driven to the DUT) and to a per-requester expected queue; a monitor
// keeps a behavioural model of grant order, flush sequencing and the
// watchdog, and pops expected beats whenever the DUT hands one on.
// Build with +define+PACKER_ARB_WDOG_EN to exercise the watchdog.
module tb_packer_arb;

   localparam int NR = 4;
   localparam int W  = 32;
   localparam int IW = 2;
   localparam int TO = 8;
`ifdef PACKER_ARB_WDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] d;
      logic [W-1:0] m;
      logic         last;
   } beat_t;

   typedef enum {M_IDLE, M_BUSY, M_FLUSH} mst_e;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   req_valid, req_last, req_ready;
   logic [NR*W-1:0] req_data, req_mask;
   logic            pk_valid, pk_ready, pk_flush, pk_flush_done;
   logic [W-1:0]    pk_data, pk_mask;
   logic            grant_valid, wdog;
   logic [IW-1:0]   grant_idx;

   int    errors = 0;
   int    checks = 0;
   beat_t src_q [NR][$];
   beat_t exp_q [NR][$];
   bit    rand_rdy = 1'b0;
   bit    rand_gap = 1'b0;
   logic  stray = 1'b0;
   int    fl_delay = 1;
   int    fl_cnt = 0;

   // Reference model state.
   mst_e m_st = M_IDLE;
   int   m_owner = 0;
   int   m_rr = 0;
   int   m_wcnt = 0;

   packer_arb #(
      .NumReq        (NR),
      .InW           (W),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_valid_i     (req_valid),
      .req_data_i      (req_data),
      .req_mask_i      (req_mask),
      .req_last_i      (req_last),
      .req_ready_o     (req_ready),
      .pk_valid_o      (pk_valid),
      .pk_data_o       (pk_data),
      .pk_mask_o       (pk_mask),
      .pk_ready_i      (pk_ready),
      .pk_flush_o      (pk_flush),
      .pk_flush_done_i (pk_flush_done),
      .grant_valid_o   (grant_valid),
      .grant_idx_o     (grant_idx),
      .wdog_o          (wdog)
   );

   // Packer flush responder: done in the fl_delay-th flush cycle; random
   // stray done pulses outside a flush must be ignored by the DUT.
   assign pk_flush_done = pk_flush ? (fl_cnt >= fl_delay - 1) : stray;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int rr);
      for (int o = 0; o < NR; o++) begin
         if (v[(rr + o) % NR]) return (rr + o) % NR;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_burst(input int k, input int len, input bit with_last);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d    = $urandom;
         b.m    = ($urandom_range(7) == 0) ? '0 : W'($urandom);
         b.last = with_last && (i == len - 1);
         src_q[k].push_back(b);
         exp_q[k].push_back(b);
      end
   endtask

   function automatic bit src_busy();
      for (int k = 0; k < NR; k++) begin
         if (src_q[k].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((src_busy() || m_st != M_IDLE) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s: still busy after %0d cycles", name, budget);
      end
   endtask

   // Source driver: handshakes sampled at negedge, queues advanced and
   // new beats driven just after the following posedge.
   initial begin : driver
      logic [NR-1:0] acc;
      bit            fl_seen, done_seen, gap;
      beat_t         b;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      req_mask  = '0;
      pk_ready  = 1'b1;
      forever begin
         @(negedge clk);
         acc       = req_valid & req_ready;
         fl_seen   = pk_flush;
         done_seen = pk_flush_done;
         @(posedge clk);
         #1;
         for (int k = 0; k < NR; k++) begin
            if (acc[k]) b = src_q[k].pop_front();
         end
         fl_cnt = (fl_seen && !done_seen && !rst) ? fl_cnt + 1 : 0;
         if (rand_rdy) pk_ready = ($urandom_range(3) != 0);
         stray = rand_gap ? 1'($urandom_range(1)) : 1'b0;
         for (int k = 0; k < NR; k++) begin
            gap = rand_gap && ($urandom_range(3) == 0);
            if (src_q[k].size() != 0 && !gap) begin
               req_valid[k]          = 1'b1;
               req_data[k*W +: W]    = src_q[k][0].d;
               req_mask[k*W +: W]    = src_q[k][0].m;
               req_last[k]           = src_q[k][0].last;
            end else begin
               req_valid[k]          = 1'b0;
               req_last[k]           = 1'($urandom_range(1));
               req_data[k*W +: W]    = $urandom;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin : monitor
      beat_t         e;
      logic [NR-1:0] exp_rdy;
      bit            exp_wd;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_st = M_IDLE;
            m_rr = 0;
         end else begin
            case (m_st)
               M_IDLE: begin
                  chk("idle_ctl", 64'({grant_valid, pk_valid, pk_flush, wdog, req_ready}), 64'(0));
                  chk("idle_data", {pk_data, pk_mask}, 64'(0));
                  if (req_valid != '0) begin
                     m_owner = pick(req_valid, m_rr);
                     m_wcnt  = 0;
                     m_st    = M_BUSY;
                  end
               end
               M_BUSY: begin
                  if (!req_valid[m_owner]) m_wcnt++;
                  exp_wd  = WD && (m_wcnt >= TO);
                  exp_rdy = '0;
                  exp_rdy[m_owner] = pk_ready;
                  chk("grant", 64'({grant_valid, grant_idx}), 64'({1'b1, IW'(m_owner)}));
                  chk("busy_ctl", 64'({pk_flush, pk_valid, wdog}), 64'({1'b0, req_valid[m_owner], exp_wd}));
                  chk("ready_vec", 64'(req_ready), 64'(exp_rdy));
                  if (req_valid[m_owner] && pk_ready) begin
                     m_wcnt = 0;
                     if (exp_q[m_owner].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_extra: got beat %0h from req %0d, expected none", pk_data, m_owner);
                     end else begin
                        e = exp_q[m_owner].pop_front();
                        chk("beat", {pk_data, pk_mask}, {e.d, e.m});
                        if (e.last) m_st = M_FLUSH;
                     end
                  end else if (exp_wd) begin
                     m_st = M_FLUSH;
                  end
               end
               default: begin
                  chk("flush_ctl", 64'({pk_flush, pk_valid, grant_valid, wdog, req_ready}), 64'(8'b1000_0000));
                  if (pk_flush_done) begin
                     m_rr = (m_owner + 1) % NR;
                     m_st = M_IDLE;
                  end
               end
            endcase
         end
      end
   end

   initial begin : sim_limit
      #500000;
      $display("FAIL sim_limit: bench did not finish in time");
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      int n;
      int total;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", 64'({req_ready, pk_valid, pk_flush, grant_valid, grant_idx, wdog}), 64'(0));
      chk("rst_data", {pk_data, pk_mask}, 64'(0));
      step();
      rst = 1'b0;

      // Single 3-beat burst from req1, flush acknowledged in 2nd cycle.
      fl_delay = 2;
      push_burst(1, 3, 1'b1);
      drain("burst_req1", 100);

      // req0 and req2 competing with repeated single-beat bursts.
      for (int i = 0; i < 4; i++) begin
         push_burst(0, 1, 1'b1);
         push_burst(2, 1, 1'b1);
      end
      drain("rr_0_2", 200);

      // Packer back-pressure for 5 cycles while req3 owns the grant.
      pk_ready = 1'b0;
      push_burst(3, 2, 1'b1);
      n = 0;
      while (!grant_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_grant_seen", 64'(grant_valid), 64'(1));
      repeat (5) begin
         @(negedge clk);
         chk("stall_ready", 64'(req_ready), 64'(0));
         chk("stall_grant", 64'({grant_valid, grant_idx}), 64'({1'b1, 2'd3}));
      end
      step();
      pk_ready = 1'b1;
      drain("stall", 100);

      // Single-cycle flush.
      fl_delay = 1;
      push_burst(2, 1, 1'b1);
      push_burst(0, 3, 1'b1);
      drain("flush_1cyc", 100);

      // Randomized traffic with back-pressure, valid gaps, stray done.
      rand_rdy = 1'b1;
      rand_gap = 1'b1;
      for (int i = 0; i < 40; i++) begin
         fl_delay = $urandom_range(1, 3);
         push_burst($urandom_range(NR - 1), $urandom_range(1, 4), 1'b1);
         repeat ($urandom_range(0, 6)) step();
      end
      drain("random", 5000);
      rand_rdy = 1'b0;
      rand_gap = 1'b0;
      step();
      pk_ready = 1'b1;

      // Reset in the middle of a flush while req3 is waiting.
      fl_delay = 30;
      push_burst(0, 1, 1'b1);
      n = 0;
      while (!pk_flush && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("mid_flush_seen", 64'(pk_flush), 64'(1));
      step();
      push_burst(3, 2, 1'b1);
      step();
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ctl", 64'({req_ready, pk_valid, pk_flush, grant_valid, grant_idx, wdog}), 64'(0));
      chk("mid_rst_data", {pk_data, pk_mask}, 64'(0));
      step();
      rst = 1'b0;
      fl_delay = 1;
      drain("after_rst", 100);

      // Owner goes silent mid-burst.
      push_burst(1, 2, 1'b0);
      n = 0;
      while (src_q[1].size() != 0 && n < 50) begin
         step();
         n++;
      end
`ifdef PACKER_ARB_WDOG_EN
      n = 0;
      for (int i = 1; i <= TO + 4 && n == 0; i++) begin
         @(negedge clk);
         if (wdog) n = i;
      end
      chk("wdog_delay", 64'(n), 64'(TO));
      drain("wdog_flush", 50);
`else
      repeat (20) @(negedge clk);
      chk("silent_busy", 64'({grant_valid, grant_idx, pk_flush, wdog}), 64'({1'b1, 2'd1, 1'b0, 1'b0}));
      push_burst(1, 1, 1'b1);
      drain("silent_end", 50);
`endif

      total = 0;
      for (int k = 0; k < NR; k++) total += exp_q[k].size();
      chk("exp_left", 64'(total), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
